// File: rtl/word_serializer_tx_pkg.sv
// Shared types and helpers for the word serializer transmitter.
// Holds the FSM state encoding and the bit-counter width calculation.
package word_serializer_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a counter that indexes every bit of a word.
  function automatic int cnt_width(input int word_length);
    return (word_length > 1) ? $clog2(word_length) : 1;
  endfunction

endpackage

// File: rtl/word_serializer_tx_shift_reg_with_load.sv
// Loadable shift register with zero fill on every shift.
// Presents the bit that is due next on serial_bit.
module word_serializer_tx_shift_reg_with_load #(
  parameter int WORD_LENGTH = 8,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   shift_en,
  input  logic [WORD_LENGTH-1:0] data,
  output logic                   serial_bit
);

  logic [WORD_LENGTH-1:0] sreg;

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= data;
    end else if (shift_en) begin
      sreg <= MSB_FIRST ? {sreg[WORD_LENGTH-2:0], 1'b0} : {1'b0, sreg[WORD_LENGTH-1:1]};
    end
  end

  assign serial_bit = MSB_FIRST ? sreg[WORD_LENGTH-1] : sreg[0];

endmodule

// File: rtl/word_serializer_tx.sv
// Parallel-in / serial-out transmitter with a valid/ready load port
// and a backpressured one-bit serial port.
module word_serializer_tx
  import word_serializer_tx_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [WORD_LENGTH-1:0] Data_Input,
  output logic                   Serial_Output,
  output logic                   serial_valid,
  input  logic                   serial_ready,
  output logic                   frame_start,
  output logic                   done
);

  localparam int              CNT_W    = cnt_width(WORD_LENGTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_LENGTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             load_fire, beat_fire, last_beat;
  logic             done_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    load_ready   = 1'b0;
    serial_valid = 1'b0;
    load_fire    = 1'b0;
    beat_fire    = 1'b0;
    last_beat    = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          load_fire = 1'b1;
          count_nxt = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        serial_valid = 1'b1;
        if (serial_ready) begin
          beat_fire = 1'b1;
          if (count == LAST_CNT) begin
            // Back to IDLE so the next word is taken one cycle later, never this cycle.
            last_beat = 1'b1;
            count_nxt = '0;
            state_nxt = IDLE;
          end else begin
            count_nxt = count + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      done_q <= last_beat;
    end
  end

  word_serializer_tx_shift_reg_with_load #(
    .WORD_LENGTH(WORD_LENGTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_shift_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load_fire),
    .shift_en  (beat_fire),
    .data      (Data_Input),
    .serial_bit(Serial_Output)
  );

  assign frame_start = (state == SHIFT) && (count == '0);
  assign done        = done_q;

endmodule

// File: tb/tb_word_serializer_tx.sv
// Scoreboard bench: three serializer builds (8-bit MSB-first, 8-bit LSB-first,
// 2-bit MSB-first); monitors pop expected bits whenever a beat is accepted.
module tb_word_serializer_tx;

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } exp_bit_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] lv, lr, so, sv, sr, fs, dn;
  logic [7:0] data_a, data_b;
  logic [1:0] data_c;

  exp_bit_t qa[$], qb[$], qc[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  word_serializer_tx #(.WORD_LENGTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(lr[0]), .Data_Input(data_a),
    .Serial_Output(so[0]), .serial_valid(sv[0]), .serial_ready(sr[0]),
    .frame_start(fs[0]), .done(dn[0]));

  word_serializer_tx #(.WORD_LENGTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(lr[1]), .Data_Input(data_b),
    .Serial_Output(so[1]), .serial_valid(sv[1]), .serial_ready(sr[1]),
    .frame_start(fs[1]), .done(dn[1]));

  word_serializer_tx #(.WORD_LENGTH(2), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .reset(reset), .load_valid(lv[2]), .load_ready(lr[2]), .Data_Input(data_c),
    .Serial_Output(so[2]), .serial_valid(sv[2]), .serial_ready(sr[2]),
    .frame_start(fs[2]), .done(dn[2]));

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int q_size(input int k);
    case (k)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic exp_bit_t q_pop(input int k);
    case (k)
      0:       return qa.pop_front();
      1:       return qb.pop_front();
      default: return qc.pop_front();
    endcase
  endfunction

  function automatic void q_clear(input int k);
    case (k)
      0:       qa.delete();
      1:       qb.delete();
      default: qc.delete();
    endcase
  endfunction

  task automatic push_word(input int k, input logic [7:0] w);
    int wl;
    bit msb;
    exp_bit_t e;
    wl  = (k == 2) ? 2 : 8;
    msb = (k != 1);
    for (int i = 0; i < wl; i++) begin
      e.b     = msb ? w[wl-1-i] : w[i];
      e.first = (i == 0);
      e.last  = (i == wl - 1);
      case (k)
        0:       qa.push_back(e);
        1:       qb.push_back(e);
        default: qc.push_back(e);
      endcase
    end
  endtask

  // Monitors: compare each accepted beat, stall stability and the done pulse.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    logic pending = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_bit = 1'b0;
    logic prev_fs = 1'b0;
    exp_bit_t e;
    always @(negedge clk) begin
      if (reset) begin
        pending    = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (pending || dn[g]) begin
          check($sformatf("dut%0d done pulse", g), dn[g], pending);
          pending = 1'b0;
        end
        if (sv[g] && prev_stall) begin
          check($sformatf("dut%0d bit stable in stall", g), so[g], prev_bit);
          check($sformatf("dut%0d frame_start stable in stall", g), fs[g], prev_fs);
        end
        if (sv[g] && sr[g]) begin
          check($sformatf("dut%0d beat expected", g), q_size(g) != 0, 1);
          if (q_size(g) != 0) begin
            e = q_pop(g);
            check($sformatf("dut%0d serial bit", g), so[g], e.b);
            check($sformatf("dut%0d frame_start", g), fs[g], e.first);
            pending = e.last;
          end
        end
        prev_stall = sv[g] && !sr[g];
        prev_bit   = so[g];
        prev_fs    = fs[g];
      end
    end
  end

  task automatic load_word(input int k, input logic [7:0] w);
    int guard = 0;
    while (!lr[k] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check($sformatf("dut%0d load_ready before load", k), lr[k], 1);
    case (k)
      0:       data_a = w;
      1:       data_b = w;
      default: data_c = w[1:0];
    endcase
    lv[k] = 1'b1;
    push_word(k, w);
    @(posedge clk); #1;
    lv[k] = 1'b0;
  endtask

  // Ends on the negedge where done is seen (or the budget runs out).
  task automatic wait_done(input int k, input int budget, output int valid_cycles,
                           output int cycles, output logic seen);
    valid_cycles = 0;
    cycles       = 0;
    seen         = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if (dn[k]) begin
        seen = 1'b1;
        break;
      end
      if (sv[k]) valid_cycles++;
    end
  endtask

  initial begin
    int   vc, cyc, beats;
    logic seen;

    reset  = 1'b1;
    lv     = '0;
    sr     = 3'b111;
    data_a = '0;
    data_b = '0;
    data_c = '0;
    #1;
    check("reset serial_valid", sv, 3'b000);
    check("reset done", dn, 3'b000);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Test 1: idle after reset, no activity without a load.
    @(negedge clk);
    check("idle load_ready", lr, 3'b111);
    check("idle serial_valid", sv, 3'b000);
    check("idle done", dn, 3'b000);
    check("idle frame_start", fs, 3'b000);
    check("idle Serial_Output", so, 3'b000);
    repeat (3) begin
      @(negedge clk);
      check("idle stays quiet", sv[0], 0);
    end
    @(posedge clk); #1;

    // Test 2: 8'hA5 MSB first at full rate.
    load_word(0, 8'hA5);
    wait_done(0, 20, vc, cyc, seen);
    check("A5 done seen", seen, 1);
    check("A5 valid cycles", vc, 8);
    check("A5 done latency", cyc, 9);
    check("A5 idle after done", sv[0], 0);
    check("A5 load_ready with done", lr[0], 1);
    @(posedge clk); #1;

    // Test 3: 8'h01 LSB first with toggling serial_ready.
    load_word(1, 8'h01);
    beats = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dn[1]) begin
        seen = 1'b1;
        break;
      end
      if (sv[1] && sr[1]) beats++;
      @(posedge clk); #1;
      sr[1] = ~sr[1];
    end
    check("01 done seen", seen, 1);
    check("01 beats", beats, 8);
    check("01 queue drained", q_size(1), 0);
    @(posedge clk); #1;
    sr[1] = 1'b1;

    // Test 4: load_valid held through FF then 00, one idle cycle between words.
    data_a = 8'hFF;
    lv[0]  = 1'b1;
    push_word(0, 8'hFF);
    @(posedge clk); #1;
    data_a = 8'h00;
    push_word(0, 8'h00);
    wait_done(0, 20, vc, cyc, seen);
    check("FF done seen", seen, 1);
    check("FF valid cycles", vc, 8);
    check("gap serial_valid", sv[0], 0);
    check("gap load_ready", lr[0], 1);
    @(posedge clk); #1;
    lv[0] = 1'b0;
    wait_done(0, 20, vc, cyc, seen);
    check("00 done seen", seen, 1);
    check("00 valid cycles", vc, 8);
    check("00 done latency", cyc, 9);
    @(posedge clk); #1;

    // Test 5: reset after three beats of C3, then a clean 3C.
    load_word(0, 8'hC3);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("async reset serial_valid", sv[0], 0);
    check("async reset Serial_Output", so[0], 0);
    check("async reset frame_start", fs[0], 0);
    check("async reset done", dn[0], 0);
    check("discarded bits left", q_size(0), 5);
    q_clear(0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no done after reset", dn[0], 0);
      check("no valid after reset", sv[0], 0);
    end
    @(posedge clk); #1;
    load_word(0, 8'h3C);
    wait_done(0, 20, vc, cyc, seen);
    check("3C done seen", seen, 1);
    check("3C valid cycles", vc, 8);
    @(posedge clk); #1;

    // Test 6: 2-bit build, counter boundary.
    load_word(2, 8'h02);
    wait_done(2, 10, vc, cyc, seen);
    check("w2 10 done seen", seen, 1);
    check("w2 10 valid cycles", vc, 2);
    check("w2 10 done latency", cyc, 3);
    @(posedge clk); #1;
    load_word(2, 8'h01);
    wait_done(2, 10, vc, cyc, seen);
    check("w2 01 done seen", seen, 1);
    check("w2 01 valid cycles", vc, 2);
    @(posedge clk); #1;

    repeat (2) @(posedge clk);
    check("scoreboard a empty", q_size(0), 0);
    check("scoreboard b empty", q_size(1), 0);
    check("scoreboard c empty", q_size(2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
